uart_key_ctrl: RTL and testbench

- Converts the byte stream from the UART receiver into timed paddle commands for players A and B, plus pause and game-restart controls.
- A serial keyboard sends only key presses, never releases. Each paddle command is therefore held for a programmable number of ticks, then auto-released.
- Sits between the UART receive path and the paddle/game logic, and replaces direct byte-to-button latching.

---
 rtl/uart_key_pkg.sv | 61 ++++++
 rtl/paddle_hold_timer.sv | 61 ++++++
 rtl/uart_key_ctrl.sv | 93 +++++++++
 tb/tb_uart_key_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_key_pkg.sv
// Shared key codes, paddle encodings and state type for the UART keyboard paddle controller.
// The byte-to-command decode lives here so that every user sees one key map.
package uart_key_pkg;

    localparam logic [7:0] KEY_W        = 8'h77;
    localparam logic [7:0] KEY_W_UC     = 8'h57;
    localparam logic [7:0] KEY_S        = 8'h73;
    localparam logic [7:0] KEY_S_UC     = 8'h53;
    localparam logic [7:0] KEY_9        = 8'h39;
    localparam logic [7:0] KEY_6        = 8'h36;
    localparam logic [7:0] KEY_SPACE    = 8'h20;
    localparam logic [7:0] KEY_R        = 8'h72;
    localparam logic [7:0] KEY_R_UC     = 8'h52;

    localparam logic [1:0] PAD_IDLE     = 2'b00;
    localparam logic [1:0] PAD_UP       = 2'b01;
    localparam logic [1:0] PAD_DOWN     = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } pad_state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_A_UP,
        CMD_A_DOWN,
        CMD_B_UP,
        CMD_B_DOWN,
        CMD_PAUSE,
        CMD_RESTART
    } key_cmd_e;

    function automatic key_cmd_e decode_key(input logic [7:0] key);
        key_cmd_e cmd;
        cmd = CMD_NONE;
        case (key)
            KEY_9:              cmd = CMD_A_UP;
            KEY_6:              cmd = CMD_A_DOWN;
            KEY_W, KEY_W_UC:    cmd = CMD_B_UP;
            KEY_S, KEY_S_UC:    cmd = CMD_B_DOWN;
            KEY_SPACE:          cmd = CMD_PAUSE;
            KEY_R, KEY_R_UC:    cmd = CMD_RESTART;
            default:            cmd = CMD_NONE;
        endcase
        return cmd;
    endfunction

    function automatic logic [1:0] pad_code(input pad_state_e st);
        logic [1:0] code;
        code = PAD_IDLE;
        case (st)
            UP:      code = PAD_UP;
            DOWN:    code = PAD_DOWN;
            default: code = PAD_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/paddle_hold_timer.sv
// One player's paddle command: latches up/down on a key press and auto-releases
// after HOLD_TICKS ticks without a further matching key.
module paddle_hold_timer
    import uart_key_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 100,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_req,
    input  logic       down_req,
    input  logic       clear,
    input  logic       tick,
    output logic [1:0] pad
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    pad_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pad_q, pad_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pad_q   <= PAD_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
        end
    end

    // Priority: clear, then a load (which beats a coincident tick), then decrement.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (up_req) begin
            state_d = UP;
            cnt_d   = HOLD_LOAD;
        end else if (down_req) begin
            state_d = DOWN;
            cnt_d   = HOLD_LOAD;
        end else if (tick && (state_q != IDLE) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
            end
        end
        pad_d = pad_code(state_d);
    end

    assign pad = pad_q;

endmodule

// File: rtl/uart_key_ctrl.sv
// Decodes UART keyboard bytes into held paddle commands for players A and B,
// plus pause toggling and a one-cycle game restart pulse.
module uart_key_ctrl
    import uart_key_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 100,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tick,
    output logic [1:0] btnA,
    output logic [1:0] btnB,
    output logic       paused,
    output logic       game_rst
);

    key_cmd_e cmd;
    logic     paused_q, paused_d;
    logic     game_rst_q, game_rst_d;
    logic     pad_clear;
    logic     a_up, a_down, b_up, b_down;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            paused_q   <= 1'b0;
            game_rst_q <= 1'b0;
        end else begin
            paused_q   <= paused_d;
            game_rst_q <= game_rst_d;
        end
    end

    always_comb begin
        cmd        = rx_valid ? decode_key(rx_data) : CMD_NONE;
        paused_d   = paused_q;
        game_rst_d = 1'b0;
        pad_clear  = 1'b0;
        a_up       = 1'b0;
        a_down     = 1'b0;
        b_up       = 1'b0;
        b_down     = 1'b0;
        case (cmd)
            CMD_RESTART: begin
                game_rst_d = 1'b1;
                paused_d   = 1'b0;
                pad_clear  = 1'b1;
            end
            CMD_PAUSE: begin
                paused_d = ~paused_q;
                // Only entering pause drops held commands; leaving restores nothing.
                pad_clear = ~paused_q;
            end
            CMD_A_UP:   a_up   = ~paused_q;
            CMD_A_DOWN: a_down = ~paused_q;
            CMD_B_UP:   b_up   = ~paused_q;
            CMD_B_DOWN: b_down = ~paused_q;
            default: ;
        endcase
    end

    paddle_hold_timer #(
        .HOLD_TICKS (HOLD_TICKS),
        .CNT_W      (CNT_W)
    ) u_pad_a (
        .clk      (clk),
        .reset    (reset),
        .up_req   (a_up),
        .down_req (a_down),
        .clear    (pad_clear),
        .tick     (tick),
        .pad      (btnA)
    );

    paddle_hold_timer #(
        .HOLD_TICKS (HOLD_TICKS),
        .CNT_W      (CNT_W)
    ) u_pad_b (
        .clk      (clk),
        .reset    (reset),
        .up_req   (b_up),
        .down_req (b_down),
        .clear    (pad_clear),
        .tick     (tick),
        .pad      (btnB)
    );

    assign paused   = paused_q;
    assign game_rst = game_rst_q;

endmodule

// File: tb/tb_uart_key_ctrl.sv
// Directed and randomized bench for uart_key_ctrl with HOLD_TICKS=4, checked
// against a per-player "direction + ticks remaining" reference model.
module tb_uart_key_ctrl;

    localparam int HOLD = 4;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tick;
    logic [1:0] btnA;
    logic [1:0] btnB;
    logic       paused;
    logic       game_rst;

    int    vectors;
    int    miscompares;
    string tag;

    // Reference model: index 0 = player A, 1 = player B; dir 0 idle, 1 up, 2 down.
    int m_dir [2];
    int m_rem [2];
    bit m_paused;
    bit m_rst;

    uart_key_ctrl #(
        .HOLD_TICKS (HOLD),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tick     (tick),
        .btnA     (btnA),
        .btnB     (btnB),
        .paused   (paused),
        .game_rst (game_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] dir_code(input int d);
        return (d == 1) ? 2'b01 : (d == 2) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_dir[p] = 0;
            m_rem[p] = 0;
        end
        m_paused = 1'b0;
        m_rst    = 1'b0;
    endtask

    task automatic model_clock(input logic v, input logic [7:0] d, input logic t);
        int ld;
        int pl;
        int dr;
        ld    = -1;
        pl    = -1;
        dr    = 0;
        m_rst = 1'b0;
        if (v) begin
            if (d == "r" || d == "R") begin
                m_rst    = 1'b1;
                m_paused = 1'b0;
                for (int p = 0; p < 2; p++) begin m_dir[p] = 0; m_rem[p] = 0; end
            end else if (d == " ") begin
                if (!m_paused)
                    for (int p = 0; p < 2; p++) begin m_dir[p] = 0; m_rem[p] = 0; end
                m_paused = !m_paused;
            end else if (d == "9") begin pl = 0; dr = 1; end
            else if (d == "6") begin pl = 0; dr = 2; end
            else if (d == "w" || d == "W") begin pl = 1; dr = 1; end
            else if (d == "s" || d == "S") begin pl = 1; dr = 2; end
        end
        if (pl >= 0 && !m_paused) begin
            m_dir[pl] = dr;
            m_rem[pl] = HOLD;
            ld = pl;
        end
        if (t) begin
            for (int p = 0; p < 2; p++) begin
                if (p != ld && m_rem[p] > 0) begin
                    m_rem[p]--;
                    if (m_rem[p] == 0) m_dir[p] = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [1:0] ea;
        logic [1:0] eb;
        ea = dir_code(m_dir[0]);
        eb = dir_code(m_dir[1]);
        vectors++;
        assert (btnA === ea) else begin
            miscompares++;
            $error("FAIL %s btnA observed=%b expected=%b", tag, btnA, ea);
        end
        vectors++;
        assert (btnB === eb) else begin
            miscompares++;
            $error("FAIL %s btnB observed=%b expected=%b", tag, btnB, eb);
        end
        vectors++;
        assert (paused === m_paused) else begin
            miscompares++;
            $error("FAIL %s paused observed=%b expected=%b", tag, paused, m_paused);
        end
        vectors++;
        assert (game_rst === m_rst) else begin
            miscompares++;
            $error("FAIL %s game_rst observed=%b expected=%b", tag, game_rst, m_rst);
        end
    endtask

    // Inputs are applied #1 after an edge, sampled on the next edge, outputs checked #1 later.
    task automatic step(input logic v, input logic [7:0] d, input logic t);
        rx_valid = v;
        rx_data  = d;
        tick     = t;
        @(posedge clk);
        model_clock(v, d, t);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick     = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic key(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'h00, 1'b1);
            idle(9);
        end
    endtask

    logic [7:0] pool [14];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        tick        = 1'b0;
        reset       = 1'b1;
        model_reset();

        tag = "reset";
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();

        tag = "w_hold";
        key("w");
        ticks(4);
        idle(3);

        tag = "9_repeat";
        key("9");
        ticks(3);
        key("9");
        ticks(4);
        idle(2);

        tag = "6_then_9";
        key("6");
        ticks(1);
        key("9");
        ticks(4);
        idle(2);

        tag = "s_with_tick";
        step(1'b1, "s", 1'b1);
        ticks(3);
        tag = "s_release";
        ticks(1);
        idle(2);

        tag = "pause";
        key("w");
        idle(2);
        key(" ");
        key("w");
        ticks(1);
        key(" ");
        idle(3);
        ticks(2);

        tag = "idle_tick";
        ticks(2);

        tag = "restart";
        key("s");
        key("9");
        ticks(1);
        key("r");
        idle(2);
        key(" ");
        key("R");
        key("r");
        key("r");
        idle(2);

        tag = "async_reset";
        key("W");
        key("6");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs();

        tag = "random";
        pool = '{"w", "W", "s", "S", "9", "6", " ", "r", "R",
                 8'h41, 8'h00, 8'hFF, "x", "7"};
        for (int i = 0; i < 1500; i++) begin
            logic       v;
            logic       t;
            logic [7:0] d;
            v = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 4) == 0);
            d = pool[$urandom_range(0, 13)];
            // Keep pause/restart rarer so holds get a chance to expire.
            if ((d == " " || d == "r" || d == "R") && $urandom_range(0, 3) != 0) d = "9";
            step(v, d, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
